branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the EX-stage branch condition evaluator of the 5-stage MIPS pipeline.
- Evaluates the full MIPS I conditional set: beq, bne, blez, bgtz, bltz, bgez.
- Computes the branch target and compares the outcome against the IF-stage prediction.
- Registers a one-cycle-latency resolution: taken, target, mispredict and redirect PC back to IF, plus a flush request to IF/ID.

Parameters:
- DATA_W, 32, operand width for A/B compare.
- PC_W, 32, program counter width.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  EX-stage instruction valid.
- op  in  3  branch op, encoded per branch_pkg: 0 NONE, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 reserved (treated as NONE).
- a  in  DATA_W  rs operand (forwarded).
- b  in  DATA_W  rt operand (forwarded); ignored for single-operand ops.
- pc_plus4  in  PC_W  PC of the branch + 4.
- imm16  in  16  raw branch offset field.
- pred_taken  in  1  prediction made at IF for this instruction.
- stall  in  1  hold the output register.
- flush  in  1  kill the current input and the held result.
- res_valid  out  1  registered result valid (branch op only).
- taken  out  1  resolved condition.
- target  out  PC_W  branch target.
- mispredict  out  1  res_valid and taken != pred_taken.
- redirect_pc  out  PC_W  taken ? target : pc_plus4.
- flush_req  out  1  equals mispredict; IF/ID flush request.

Behaviour:
- Reset (async, rst=1): res_valid=0, taken=0, target=0, mispredict=0, redirect_pc=0, flush_req=0, and counters=0. All outputs are driven from flops.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Condition (signed compare on DATA_W):
  - BEQ: a==b.
  - BNE: a!=b.
  - BLEZ: a<=0.
  - BGTZ: a>0.
  - BLTZ: a<0.
  - BGEZ: a>=0.
  - NONE/reserved: 0.
- target = pc_plus4 + (sign_extend(imm16) << 2), truncated to PC_W. Wraps modulo 2^PC_W with no overflow flag.
- Register update priority per edge:
  - flush: res_valid, mispredict and flush_req go to 0; data fields may update.
  - else stall: all output registers hold.
  - else: load; res_valid = valid_in and op is a branch op.
- flush and stall asserted together: flush wins.
- Non-branch or invalid input: res_valid=0, mispredict=0, taken=0; target and redirect_pc still load (don't-care to consumers).
- mispredict and flush_req are single-cycle pulses unless stall holds them. A held pulse must not be double-counted by the stats.
- rst asserted mid-stream clears immediately, without waiting for a clock edge.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs br_count, taken_count and mispred_count, each CNT_W.
  - Each counter increments on a load edge (not stall, not flush) whose new result is a valid branch / taken branch / mispredict respectively.
  - Counters saturate at all-ones and clear on rst.
- Undefined: the ports and counters are absent, and the behaviour is otherwise identical.

Decomposition:
- branch_pkg holds:
  - op encodings BR_NONE..BR_BGEZ as a 3-bit typedef;
  - an is_branch_op() function;
  - the default widths.
- One sub-module, branch_cond_cmp: purely combinational (op, a, b) -> cond. Instanced once and reusable by a future ID-stage early-branch unit.

Test Plan:
- BEQ, a=5, b=5, pc_plus4=0x100, imm16=0x0004, pred_taken=0 -> next cycle: taken=1, target=0x110, mispredict=1, redirect_pc=0x110.
- BLTZ, a=0x80000000, imm16=0xFFFF, pc_plus4=0x200, pred_taken=1 -> taken=1, target=0x1FC, mispredict=0, flush_req=0.
- BGTZ, a=0, pred_taken=1 -> taken=0, mispredict=1, redirect_pc=pc_plus4. Then stall=1 for 2 cycles -> outputs held for both. With BRANCH_STATS_EN, mispred_count=1, not 3.
- Mispredicting BNE result registered, then flush=1 together with stall=1 -> next cycle res_valid=0, mispredict=0.
- Target wrap: pc_plus4=0xFFFFFFFC, imm16=0x0002, BEQ taken -> target=0x00000004.
- rst pulsed asynchronously mid-cycle while res_valid=1 -> all outputs 0 before the next edge. With BRANCH_STATS_EN, preload by CNT_W=2 then 4 taken branches -> taken_count saturates at 3.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types, op encodings and default widths for the EX-stage branch resolution logic.
package branch_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned IMM_W      = 16;

  typedef enum logic [OP_W-1:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  // True for the six real conditional branches; NONE and the reserved code are not branches.
  function automatic logic is_branch_op(input logic [OP_W-1:0] op);
    return (op >= BR_BEQ) && (op <= BR_BGEZ);
  endfunction

endpackage

// File: rtl/branch_cond_cmp.sv
// Combinational MIPS I branch condition evaluator: (op, a, b) -> cond.
module branch_cond_cmp
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              cond_c
);

  logic a_neg;
  logic a_zero;
  logic a_eq_b;

  // Signed compares against zero reduce to sign bit and zero detect.
  assign a_neg  = a_i[DATA_W-1];
  assign a_zero = (a_i == '0);
  assign a_eq_b = (a_i == b_i);

  always_comb begin
    cond_c = 1'b0;
    case (br_op_e'(op_i))
      BR_BEQ:  cond_c = a_eq_b;
      BR_BNE:  cond_c = !a_eq_b;
      BR_BLEZ: cond_c = a_neg || a_zero;
      BR_BGTZ: cond_c = !a_neg && !a_zero;
      BR_BLTZ: cond_c = a_neg;
      BR_BGEZ: cond_c = !a_neg;
      default: cond_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: condition, target, mispredict and redirect, registered with 1-cycle latency.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PC_W   = DEF_PC_W
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned CNT_W  = DEF_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [PC_W-1:0]   pc_plus4,
  input  logic [IMM_W-1:0]  imm16,
  input  logic              pred_taken,
  input  logic              stall,
  input  logic              flush,
  output logic              res_valid,
  output logic              taken,
  output logic [PC_W-1:0]   target,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush_req
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count,
  output logic [CNT_W-1:0]  mispred_count
`endif
);

  logic            cond;
  logic            ld_valid;
  logic            ld_taken;
  logic            ld_mis;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] ld_target;
  logic [PC_W-1:0] ld_redirect;

  logic            res_valid_q,  res_valid_d;
  logic            taken_q,      taken_d;
  logic [PC_W-1:0] target_q,     target_d;
  logic            mispredict_q, mispredict_d;
  logic [PC_W-1:0] redirect_q,   redirect_d;
  logic            flush_req_q,  flush_req_d;

  branch_cond_cmp #(
    .DATA_W (DATA_W)
  ) u_cond (
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .cond_c (cond)
  );

  // Values a normal load edge would capture.
  assign ld_valid    = valid_in && is_branch_op(op);
  assign ld_taken    = ld_valid && cond;
  assign ld_mis      = ld_valid && (cond != pred_taken);
  assign offset      = PC_W'($signed({imm16, 2'b00}));
  assign ld_target   = pc_plus4 + offset;
  assign ld_redirect = ld_taken ? ld_target : pc_plus4;

  // Flush kills the result but lets data fields load; stall holds everything.
  always_comb begin
    res_valid_d  = res_valid_q;
    taken_d      = taken_q;
    target_d     = target_q;
    mispredict_d = mispredict_q;
    redirect_d   = redirect_q;
    flush_req_d  = flush_req_q;
    if (flush) begin
      res_valid_d  = 1'b0;
      mispredict_d = 1'b0;
      flush_req_d  = 1'b0;
      taken_d      = ld_taken;
      target_d     = ld_target;
      redirect_d   = ld_redirect;
    end else if (!stall) begin
      res_valid_d  = ld_valid;
      taken_d      = ld_taken;
      target_d     = ld_target;
      mispredict_d = ld_mis;
      redirect_d   = ld_redirect;
      flush_req_d  = ld_mis;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      flush_req_q  <= 1'b0;
    end else begin
      res_valid_q  <= res_valid_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      flush_req_q  <= flush_req_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign taken       = taken_q;
  assign target      = target_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;
  assign flush_req   = flush_req_q;

`ifdef BRANCH_STATS_EN
  logic             load_en;
  logic [CNT_W-1:0] br_cnt_q,  br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q,  tk_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  // Count only on load edges so a stalled pulse is seen once.
  assign load_en   = !flush && !stall;
  assign br_cnt_d  = sat_inc(br_cnt_q,  load_en && ld_valid);
  assign tk_cnt_d  = sat_inc(tk_cnt_q,  load_en && ld_taken);
  assign mis_cnt_d = sat_inc(mis_cnt_q, load_en && ld_mis);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q  <= '0;
      tk_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      tk_cnt_q  <= tk_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_count      = br_cnt_q;
  assign taken_count   = tk_cnt_q;
  assign mispred_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit against a rule-level reference model.
module tb_branch_resolve_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 32;
`ifdef BRANCH_STATS_EN
  localparam int unsigned TB_CNT_W = 2;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [PW-1:0] pc_plus4 = '0;
  logic [15:0]   imm16 = '0;
  logic          pred_taken = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          res_valid, taken, mispredict, flush_req;
  logic [PW-1:0] target, redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [TB_CNT_W-1:0] br_count, taken_count, mispred_count;
`endif

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic          m_valid, m_taken, m_mis, m_known;
  logic [PW-1:0] m_target, m_redir;
  int            m_br, m_tk, m_mc;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .DATA_W (DW),
    .PC_W   (PW)
`ifdef BRANCH_STATS_EN
    ,
    .CNT_W  (TB_CNT_W)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .op          (op),
    .a           (a),
    .b           (b),
    .pc_plus4    (pc_plus4),
    .imm16       (imm16),
    .pred_taken  (pred_taken),
    .stall       (stall),
    .flush       (flush),
    .res_valid   (res_valid),
    .taken       (taken),
    .target      (target),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc),
    .flush_req   (flush_req)
`ifdef BRANCH_STATS_EN
    ,
    .br_count      (br_count),
    .taken_count   (taken_count),
    .mispred_count (mispred_count)
`endif
  );

  function automatic logic ref_cond(input logic [2:0] o, input logic signed [DW-1:0] x,
                                    input logic signed [DW-1:0] y);
    case (o)
      3'd1:    return x == y;
      3'd2:    return x != y;
      3'd3:    return x <= 0;
      3'd4:    return x > 0;
      3'd5:    return x < 0;
      3'd6:    return x >= 0;
      default: return 1'b0;
    endcase
  endfunction

  // Model tracks every edge, independent of which test is driving.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_taken = 0; m_mis = 0; m_known = 1;
      m_target = '0; m_redir = '0;
      m_br = 0; m_tk = 0; m_mc = 0;
    end else begin
      logic          v, c;
      logic [PW-1:0] t;
      int            off;
      v   = valid_in && (op >= 3'd1) && (op <= 3'd6);
      c   = v && ref_cond(op, a, b);
      off = int'($signed(imm16)) * 4;
      t   = pc_plus4 + PW'(off);
      if (flush) begin
        m_valid = 0; m_mis = 0; m_known = 0;
      end else if (!stall) begin
        m_valid = v; m_taken = c; m_target = t; m_known = 1;
        m_mis = v && (c != pred_taken);
        m_redir = c ? t : pc_plus4;
`ifdef BRANCH_STATS_EN
        if (v && m_br < CNT_MAX) m_br++;
        if (c && m_tk < CNT_MAX) m_tk++;
        if (m_mis && m_mc < CNT_MAX) m_mc++;
`endif
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] o, input logic [DW-1:0] aa,
                       input logic [DW-1:0] bb, input logic [PW-1:0] pc, input logic [15:0] im,
                       input logic pt, input logic st, input logic fl);
    valid_in = v; op = o; a = aa; b = bb; pc_plus4 = pc; imm16 = im;
    pred_taken = pt; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    valid_in = 0; stall = 0; flush = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({res_valid, taken, mispredict, flush_req} !== 4'b0 || target !== '0 || redirect_pc !== '0)
      $display("FAIL reset_outputs: got v%b t%b m%b f%b tgt=%h rpc=%h, want all zero",
               res_valid, taken, mispredict, flush_req, target, redirect_pc);
    else passed++;
`ifdef BRANCH_STATS_EN
    checks++;
    if (br_count !== '0 || taken_count !== '0 || mispred_count !== '0)
      $display("FAIL reset_counters: got %0d %0d %0d, want 0 0 0", br_count, taken_count, mispred_count);
    else passed++;
`endif
    #1 rst = 1'b0;
  endtask

  task automatic test_beq();
    drive(1, 3'd1, 32'd5, 32'd5, 32'h100, 16'h0004, 0, 0, 0);
    checks++;
    if (res_valid !== 1 || taken !== 1 || target !== 32'h110 || mispredict !== 1 ||
        redirect_pc !== 32'h110 || flush_req !== 1)
      $display("FAIL beq_taken: got v%b t%b tgt=%h m%b rpc=%h f%b, want v1 t1 tgt=110 m1 rpc=110 f1",
               res_valid, taken, target, mispredict, redirect_pc, flush_req);
    else passed++;
  endtask

  task automatic test_bltz();
    drive(1, 3'd5, 32'h8000_0000, 32'd0, 32'h200, 16'hFFFF, 1, 0, 0);
    checks++;
    if (taken !== 1 || target !== 32'h1FC || mispredict !== 0 || flush_req !== 0 || res_valid !== 1)
      $display("FAIL bltz_neg_offset: got t%b tgt=%h m%b f%b v%b, want t1 tgt=1fc m0 f0 v1",
               taken, target, mispredict, flush_req, res_valid);
    else passed++;
  endtask

  task automatic test_stall_hold();
    do_reset();
    drive(1, 3'd4, 32'd0, 32'd9, 32'h300, 16'h0010, 1, 0, 0);
    checks++;
    if (taken !== 0 || mispredict !== 1 || redirect_pc !== 32'h300 || target !== 32'h340)
      $display("FAIL bgtz_zero: got t%b m%b rpc=%h tgt=%h, want t0 m1 rpc=300 tgt=340",
               taken, mispredict, redirect_pc, target);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      drive(1, 3'd1, 32'd7, 32'd7, 32'h900, 16'h0100, 0, 1, 0);
      checks++;
      if (res_valid !== 1 || taken !== 0 || mispredict !== 1 || flush_req !== 1 ||
          redirect_pc !== 32'h300 || target !== 32'h340)
        $display("FAIL stall_hold_%0d: got v%b t%b m%b f%b rpc=%h tgt=%h, want v1 t0 m1 f1 rpc=300 tgt=340",
                 i, res_valid, taken, mispredict, flush_req, redirect_pc, target);
      else passed++;
    end
`ifdef BRANCH_STATS_EN
    checks++;
    if (mispred_count !== TB_CNT_W'(1) || br_count !== TB_CNT_W'(1))
      $display("FAIL stall_no_double_count: got mis=%0d br=%0d, want 1 1", mispred_count, br_count);
    else passed++;
`endif
  endtask

  task automatic test_flush_over_stall();
    drive(1, 3'd2, 32'd1, 32'd2, 32'h400, 16'h0008, 0, 0, 0);
    checks++;
    if (mispredict !== 1 || res_valid !== 1)
      $display("FAIL bne_mispredict: got m%b v%b, want m1 v1", mispredict, res_valid);
    else passed++;
    drive(1, 3'd2, 32'd1, 32'd2, 32'h400, 16'h0008, 0, 1, 1);
    checks++;
    if (res_valid !== 0 || mispredict !== 0 || flush_req !== 0)
      $display("FAIL flush_wins: got v%b m%b f%b, want v0 m0 f0", res_valid, mispredict, flush_req);
    else passed++;
  endtask

  task automatic test_target_wrap();
    drive(1, 3'd1, 32'hABCD, 32'hABCD, 32'hFFFF_FFFC, 16'h0002, 1, 0, 0);
    checks++;
    if (target !== 32'h4 || taken !== 1 || redirect_pc !== 32'h4 || mispredict !== 0)
      $display("FAIL target_wrap: got tgt=%h t%b rpc=%h m%b, want tgt=4 t1 rpc=4 m0",
               target, taken, redirect_pc, mispredict);
    else passed++;
  endtask

  task automatic test_async_reset();
    drive(1, 3'd6, 32'd3, 32'd0, 32'h500, 16'h0001, 0, 0, 0);
    checks++;
    if (res_valid !== 1 || taken !== 1)
      $display("FAIL pre_reset_valid: got v%b t%b, want v1 t1", res_valid, taken);
    else passed++;
    valid_in = 0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({res_valid, taken, mispredict, flush_req} !== 4'b0 || target !== '0 || redirect_pc !== '0)
      $display("FAIL async_reset: got v%b t%b m%b f%b tgt=%h rpc=%h, want all zero before edge",
               res_valid, taken, mispredict, flush_req, target, redirect_pc);
    else passed++;
    #1 rst = 1'b0;
`ifdef BRANCH_STATS_EN
    for (int i = 0; i < 4; i++) drive(1, 3'd1, 32'd1, 32'd1, 32'h600, 16'h0, 1, 0, 0);
    checks++;
    if (taken_count !== TB_CNT_W'(CNT_MAX) || br_count !== TB_CNT_W'(CNT_MAX))
      $display("FAIL counter_saturate: got tk=%0d br=%0d, want %0d", taken_count, br_count, CNT_MAX);
    else passed++;
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] ra, rb;
      logic [2:0]    ro;
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = '0;
        1:       ra = DW'($urandom) | 32'h8000_0000;
        default: ra = DW'($urandom_range(0, 20));
      endcase
      rb = ($urandom_range(0, 2) == 0) ? ra : DW'($urandom_range(0, 20));
      drive(($urandom_range(0, 7) != 0), ro, ra, rb, PW'($urandom), 16'($urandom),
            1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      checks++;
      if (res_valid !== m_valid || mispredict !== m_mis || flush_req !== m_mis)
        $display("FAIL rand_ctrl[%0d]: got v%b m%b f%b, want v%b m%b f%b",
                 i, res_valid, mispredict, flush_req, m_valid, m_mis, m_mis);
      else passed++;
      if (m_known) begin
        checks++;
        if (taken !== m_taken || target !== m_target || redirect_pc !== m_redir)
          $display("FAIL rand_data[%0d]: got t%b tgt=%h rpc=%h, want t%b tgt=%h rpc=%h",
                   i, taken, target, redirect_pc, m_taken, m_target, m_redir);
        else passed++;
      end
`ifdef BRANCH_STATS_EN
      checks++;
      if (br_count !== TB_CNT_W'(m_br) || taken_count !== TB_CNT_W'(m_tk) ||
          mispred_count !== TB_CNT_W'(m_mc))
        $display("FAIL rand_cnt[%0d]: got %0d %0d %0d, want %0d %0d %0d",
                 i, br_count, taken_count, mispred_count, m_br, m_tk, m_mc);
      else passed++;
      if ($urandom_range(0, 15) == 0) do_reset();
`endif
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bltz();
    test_stall_hold();
    test_flush_over_stall();
    test_target_wrap();
    test_async_reset();
    do_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
